// File: rtl/rect_draw_engine.sv
// Rectangle rasteriser: buffers up to two fill commands and streams one
// pixel per clock to a VGA frame-buffer adapter, clipping off-screen pixels.
module rect_draw_engine #(
  parameter int unsigned X_WIDTH      = 8,
  parameter int unsigned Y_WIDTH      = 8,
  parameter int unsigned DIM_WIDTH    = 8,
  parameter int unsigned COLOUR_WIDTH = 3,
  parameter int unsigned SCREEN_W     = 160,
  parameter int unsigned SCREEN_H     = 120
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic [X_WIDTH-1:0]      cmd_x,
  input  logic [Y_WIDTH-1:0]      cmd_y,
  input  logic [DIM_WIDTH-1:0]    cmd_w,
  input  logic [DIM_WIDTH-1:0]    cmd_h,
  input  logic [COLOUR_WIDTH-1:0] cmd_colour,
  input  logic                    flush,
  output logic [X_WIDTH-1:0]      x,
  output logic [Y_WIDTH-1:0]      y,
  output logic [COLOUR_WIDTH-1:0] colour,
  output logic                    plot,
  output logic                    busy,
  output logic                    done
);

  localparam int unsigned SX_W  = X_WIDTH + 1;
  localparam int unsigned SY_W  = Y_WIDTH + 1;
  localparam int unsigned CNT_W = 2;

  typedef struct packed {
    logic [X_WIDTH-1:0]      x;
    logic [Y_WIDTH-1:0]      y;
    logic [DIM_WIDTH-1:0]    w;
    logic [DIM_WIDTH-1:0]    h;
    logic [COLOUR_WIDTH-1:0] colour;
  } cmd_t;

  typedef enum logic {S_IDLE, S_DRAW} state_t;

  state_t                  state_q, state_d;
  logic [CNT_W-1:0]        count_q, count_d;
  cmd_t [1:0]              mem_q, mem_d;
  cmd_t                    cur_q, cur_d;
  logic [DIM_WIDTH-1:0]    col_q, col_d;
  logic [DIM_WIDTH-1:0]    row_q, row_d;
  logic [X_WIDTH-1:0]      x_q, x_d;
  logic [Y_WIDTH-1:0]      y_q, y_d;
  logic [COLOUR_WIDTH-1:0] colour_q, colour_d;
  logic                    plot_q, plot_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;

  cmd_t                    cmd_in;
  logic                    push, pop, cur_last;
  logic [CNT_W-1:0]        cnt_after_pop;
  logic [SX_W-1:0]         sum_x;
  logic [SY_W-1:0]         sum_y;

  // True when (col,row) is the final pixel cycle of command c
  function automatic logic is_last(input cmd_t c, input logic [DIM_WIDTH-1:0] col,
                                   input logic [DIM_WIDTH-1:0] row);
    return (c.w == '0) || (c.h == '0) ||
           ((col == c.w - DIM_WIDTH'(1)) && (row == c.h - DIM_WIDTH'(1)));
  endfunction

  // Ready derives from the registered count only, so a same-cycle pop never frees a slot
  assign cmd_ready = (count_q < CNT_W'(2)) && !reset;

  assign x      = x_q;
  assign y      = y_q;
  assign colour = colour_q;
  assign plot   = plot_q;
  assign busy   = busy_q;
  assign done   = done_q;

  // Next-state, FIFO and pixel computation
  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    mem_d    = mem_q;
    cur_d    = cur_q;
    col_d    = col_q;
    row_d    = row_q;
    x_d      = x_q;
    y_d      = y_q;
    colour_d = colour_q;
    plot_d   = 1'b0;
    done_d   = 1'b0;
    pop      = 1'b0;

    cmd_in.x      = cmd_x;
    cmd_in.y      = cmd_y;
    cmd_in.w      = cmd_w;
    cmd_in.h      = cmd_h;
    cmd_in.colour = cmd_colour;

    push     = cmd_valid && cmd_ready && !flush;
    cur_last = is_last(cur_q, col_q, row_q);

    if (flush) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (count_q != '0) pop = 1'b1;
        end
        S_DRAW: begin
          if (cur_last) begin
            if (count_q != '0) pop = 1'b1;
            else               state_d = S_IDLE;
          end else if (col_q == cur_q.w - DIM_WIDTH'(1)) begin
            col_d = '0;
            row_d = row_q + DIM_WIDTH'(1);
          end else begin
            col_d = col_q + DIM_WIDTH'(1);
          end
        end
        default: state_d = S_IDLE;
      endcase
    end

    if (pop) begin
      state_d = S_DRAW;
      cur_d   = mem_q[0];
      col_d   = '0;
      row_d   = '0;
    end

    cnt_after_pop = count_q - CNT_W'(pop);
    if (pop)  mem_d[0] = mem_q[1];
    if (push) mem_d[cnt_after_pop[0]] = cmd_in;
    count_d = flush ? '0 : (cnt_after_pop + CNT_W'(push));

    // Sums are one bit wider than the screen coordinate so overflow clips instead of wrapping
    sum_x = SX_W'(cur_d.x) + SX_W'(col_d);
    sum_y = SY_W'(cur_d.y) + SY_W'(row_d);
    if (state_d == S_DRAW) begin
      x_d      = sum_x[X_WIDTH-1:0];
      y_d      = sum_y[Y_WIDTH-1:0];
      colour_d = cur_d.colour;
      plot_d   = (cur_d.w != '0) && (cur_d.h != '0) &&
                 (sum_x < SX_W'(SCREEN_W)) && (sum_y < SY_W'(SCREEN_H));
      done_d   = is_last(cur_d, col_d, row_d);
    end

    busy_d = (state_d == S_DRAW) || (count_d != '0);
  end

  // State and registered outputs with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      count_q  <= '0;
      mem_q    <= '0;
      cur_q    <= '0;
      col_q    <= '0;
      row_q    <= '0;
      x_q      <= '0;
      y_q      <= '0;
      colour_q <= '0;
      plot_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      mem_q    <= mem_d;
      cur_q    <= cur_d;
      col_q    <= col_d;
      row_q    <= row_d;
      x_q      <= x_d;
      y_q      <= y_d;
      colour_q <= colour_d;
      plot_q   <= plot_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

endmodule

// File: tb/tb_rect_draw_engine.sv
// Bench for rect_draw_engine: table of rectangles with hand-computed cycle and
// plot counts, a pixel scoreboard, and hand sequences for queueing, flush and reset.
module tb_rect_draw_engine;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [7:0] cmd_x = '0, cmd_y = '0, cmd_w = '0, cmd_h = '0;
  logic [2:0] cmd_colour = '0;
  logic       flush = 1'b0;
  logic [7:0] x, y;
  logic [2:0] colour;
  logic       plot, busy, done;

  rect_draw_engine dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_x(cmd_x), .cmd_y(cmd_y), .cmd_w(cmd_w), .cmd_h(cmd_h),
    .cmd_colour(cmd_colour), .flush(flush), .x(x), .y(y), .colour(colour),
    .plot(plot), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct {
    logic [7:0] x;
    logic [7:0] y;
    logic [2:0] colour;
    logic       plot;
    logic       done;
  } ev_t;

  typedef struct {
    int x; int y; int w; int h; int col;
    int plots; int cycles;
  } vec_t;

  ev_t exp_q[$];
  int  done_cyc[$];
  int  errors = 0;
  int  checks = 0;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d required %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected visible events (plotted pixels and done pulses) for one command
  task automatic push_expected(input int cx, input int cy, input int w, input int h, input int col);
    if (w == 0 || h == 0) begin
      exp_q.push_back(ev_t'{x: 8'(cx), y: 8'(cy), colour: 3'(col), plot: 1'b0, done: 1'b1});
    end else begin
      for (int r = 0; r < h; r++) begin
        for (int c = 0; c < w; c++) begin
          int  sx, sy;
          logic p, d;
          sx = cx + c;
          sy = cy + r;
          p  = (sx < 160) && (sy < 120);
          d  = (c == w - 1) && (r == h - 1);
          if (p || d)
            exp_q.push_back(ev_t'{x: 8'(sx), y: 8'(sy), colour: 3'(col), plot: p, done: d});
        end
      end
    end
  endtask

  // Presents a command and returns just after the edge that accepts it; cmd_valid stays high
  task automatic send(input int cx, input int cy, input int w, input int h, input int col);
    int n;
    cmd_x = 8'(cx); cmd_y = 8'(cy); cmd_w = 8'(w); cmd_h = 8'(h); cmd_colour = 3'(col);
    cmd_valid = 1'b1;
    n = 0;
    while (!cmd_ready && n < 200) begin
      tick();
      n++;
    end
    if (!cmd_ready) check("ready_timeout", 0, 1);
    push_expected(cx, cy, w, h, col);
    tick();
  endtask

  // Scoreboard: compare every visible DUT event against the expected stream
  always @(negedge clk) begin
    ev_t e;
    if (!reset && (plot || done)) begin
      if (done) done_cyc.push_back(int'(cyc));
      if (exp_q.size() == 0) begin
        check("unexpected_event", 1, 0);
      end else begin
        e = exp_q.pop_front();
        check("ev_plot", int'(plot), int'(e.plot));
        check("ev_done", int'(done), int'(e.done));
        if (e.plot) begin
          check("ev_x", int'(x), int'(e.x));
          check("ev_y", int'(y), int'(e.y));
          check("ev_colour", int'(colour), int'(e.colour));
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t tbl[9];
    int   n, np, n_ev;
    logic seen;

    tbl[0] = '{x: 10,  y: 20,  w: 2,  h: 2,  col: 5, plots: 4, cycles: 4};
    tbl[1] = '{x: 158, y: 118, w: 4,  h: 4,  col: 3, plots: 4, cycles: 16};
    tbl[2] = '{x: 30,  y: 40,  w: 0,  h: 7,  col: 2, plots: 0, cycles: 1};
    tbl[3] = '{x: 5,   y: 5,   w: 3,  h: 1,  col: 1, plots: 3, cycles: 3};
    tbl[4] = '{x: 159, y: 0,   w: 1,  h: 3,  col: 7, plots: 3, cycles: 3};
    tbl[5] = '{x: 200, y: 10,  w: 2,  h: 2,  col: 2, plots: 0, cycles: 4};
    tbl[6] = '{x: 0,   y: 119, w: 3,  h: 2,  col: 6, plots: 3, cycles: 6};
    tbl[7] = '{x: 4,   y: 4,   w: 0,  h: 0,  col: 4, plots: 0, cycles: 1};
    tbl[8] = '{x: 250, y: 250, w: 10, h: 10, col: 1, plots: 0, cycles: 100};

    // Reset: outputs cleared, ready low, a command presented during reset is dropped
    reset = 1'b1;
    cmd_x = 8'd9; cmd_y = 8'd9; cmd_w = 8'd1; cmd_h = 8'd1; cmd_colour = 3'd1;
    cmd_valid = 1'b1;
    tick(); tick();
    check("rst_x", int'(x), 0);
    check("rst_y", int'(y), 0);
    check("rst_colour", int'(colour), 0);
    check("rst_plot", int'(plot), 0);
    check("rst_done", int'(done), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_ready", int'(cmd_ready), 0);
    cmd_valid = 1'b0;
    reset = 1'b0;
    #1;
    check("ready_after_rst", int'(cmd_ready), 1);
    tick(); tick();
    check("rst_cmd_dropped", int'(busy), 0);

    // Table: one command at a time from idle
    foreach (tbl[i]) begin
      send(tbl[i].x, tbl[i].y, tbl[i].w, tbl[i].h, tbl[i].col);
      cmd_valid = 1'b0;
      check("busy_after_accept", int'(busy), 1);
      tick();
      n = 0; np = 0; seen = 1'b0;
      while (!seen && n < 300) begin
        n++;
        if (plot) np++;
        if (done) seen = 1'b1;
        else      tick();
      end
      check("vec_done_seen", int'(seen), 1);
      check("vec_cycles", n, tbl[i].cycles);
      check("vec_plots", np, tbl[i].plots);
      tick();
      check("vec_plot_after", int'(plot), 0);
      check("vec_done_after", int'(done), 0);
      check("vec_busy_after", int'(busy), 0);
    end

    // Queueing: cmd_valid held across four commands, FIFO fills behind a 2x2
    done_cyc.delete();
    send(40, 40, 2, 2, 2);
    send(1, 1, 1, 1, 1);
    send(2, 2, 1, 1, 2);
    check("ready_full", int'(cmd_ready), 0);
    send(3, 3, 1, 1, 3);
    cmd_valid = 1'b0;
    n = 0;
    while (done_cyc.size() < 4 && n < 50) begin
      tick();
      n++;
    end
    repeat (5) tick();
    check("b2b_done_count", done_cyc.size(), 4);
    if (done_cyc.size() >= 4) begin
      for (int k = 1; k < 4; k++) check("b2b_gap", done_cyc[k] - done_cyc[k-1], 1);
    end
    check("b2b_busy_end", int'(busy), 0);

    // Flush at pixel 5 of a 10x10 with a second command queued
    send(20, 30, 10, 10, 4);
    cmd_valid = 1'b0;
    tick();
    send(60, 60, 3, 3, 6);
    cmd_valid = 1'b0;
    tick(); tick(); tick();
    check("flush_p5_x", int'(x), 24);
    check("flush_p5_plot", int'(plot), 1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    exp_q.delete();
    check("flush_plot", int'(plot), 0);
    check("flush_done", int'(done), 0);
    check("flush_busy", int'(busy), 0);
    n_ev = 0;
    repeat (60) begin
      tick();
      if (plot || done) n_ev++;
    end
    check("flush_no_draw", n_ev, 0);

    // Reset during pixel 3 of a 4x4, then a fresh command
    send(30, 30, 4, 4, 5);
    cmd_valid = 1'b0;
    tick(); tick(); tick();
    reset = 1'b1;
    exp_q.delete();
    tick();
    check("midrst_x", int'(x), 0);
    check("midrst_y", int'(y), 0);
    check("midrst_colour", int'(colour), 0);
    check("midrst_plot", int'(plot), 0);
    check("midrst_done", int'(done), 0);
    check("midrst_busy", int'(busy), 0);
    check("midrst_ready", int'(cmd_ready), 0);
    reset = 1'b0;
    #1;
    check("midrst_ready_after", int'(cmd_ready), 1);
    send(7, 8, 2, 1, 3);
    cmd_valid = 1'b0;
    tick();
    check("post_p1_plot", int'(plot), 1);
    check("post_p1_x", int'(x), 7);
    check("post_p1_y", int'(y), 8);
    tick();
    check("post_p2_x", int'(x), 8);
    check("post_p2_done", int'(done), 1);
    tick();
    check("post_plot_after", int'(plot), 0);
    check("post_busy_after", int'(busy), 0);

    repeat (3) tick();
    check("sb_leftover", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
